// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction queue.
// Records are sized for the widest supported PC; the top uses the low XLEN bits.
package branch_resolver_pkg;

  localparam int PC_MAX = 64;

  // update_pc carries this value in every cycle without a predictor update
  localparam logic [PC_MAX-1:0] NO_UPDATE_PC = '1;

  typedef struct packed {
    logic [PC_MAX-1:0] pc;
    logic [PC_MAX-1:0] pred_next_pc;
    logic              pred_taken;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-flight prediction queue: DEPTH records, head visible combinationally so the
// resolver can compare against it in the cycle the instruction resolves.
module pred_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  pred_rec_t wr_data,
  input  logic      pop,
  input  logic      clear,
  output pred_rec_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pred_rec_t         mem [DEPTH];
  logic [AW-1:0]     head_reg;
  logic [AW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;
  logic              do_pop;
  logic              do_push;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full queue still takes the push
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[head_reg];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) begin
      mem[tail_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + AW'(1);
      if (do_pop)  head_reg <= head_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves the oldest in-flight prediction against the executed outcome, raising a
// registered flush/redirect and predictor training. Optional: BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pred_next_pc,
  input  logic            fetch_pred_taken,
  output logic            fetch_ready,
  input  logic            ex_valid,
  input  logic            ex_is_ctrl,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] update_pc,
  output logic [XLEN-1:0] update_BTB,
  output logic            update_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            err_underflow
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]     stat_ctrl,
  output logic [31:0]     stat_mispredict
`endif
);

  localparam logic [XLEN-1:0] NO_UPD = NO_UPDATE_PC[XLEN-1:0];

  pred_rec_t       wr_rec;
  pred_rec_t       head_rec;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop_now;
  logic            ctrl_pop;
  logic            flush_now;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] actual_next;
  logic            unused_rec;

  logic [XLEN-1:0] update_pc_reg;
  logic [XLEN-1:0] update_btb_reg;
  logic            update_taken_reg;
  logic            flush_reg;
  logic [XLEN-1:0] redirect_pc_reg;
  logic            err_underflow_reg;

  assign wr_rec = '{pc:           PC_MAX'(fetch_pc),
                    pred_next_pc: PC_MAX'(fetch_pred_next_pc),
                    pred_taken:   fetch_pred_taken};

  pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fetch_valid && !flush_now),
    .wr_data (wr_rec),
    .pop     (pop_now),
    .clear   (flush_now),
    .rd_data (head_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // pred_taken and the upper record bits are kept for debug only
  assign unused_rec = ^head_rec;

  assign fetch_ready = !fifo_full;
  assign pop_now     = ex_valid && !fifo_empty;
  assign ctrl_pop    = pop_now && ex_is_ctrl;
  assign head_pc     = head_rec.pc[XLEN-1:0];
  assign actual_next = ex_taken ? ex_target : head_pc + XLEN'(4);
  // any instruction whose real successor differs from the prediction mispredicts
  assign flush_now   = pop_now && (actual_next != head_rec.pred_next_pc[XLEN-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      update_pc_reg     <= NO_UPD;
      update_btb_reg    <= '0;
      update_taken_reg  <= 1'b0;
      flush_reg         <= 1'b0;
      redirect_pc_reg   <= '0;
      err_underflow_reg <= 1'b0;
    end else begin
      update_pc_reg     <= ctrl_pop ? head_pc : NO_UPD;
      update_btb_reg    <= ctrl_pop ? ex_target : '0;
      update_taken_reg  <= ctrl_pop && ex_taken;
      flush_reg         <= flush_now;
      redirect_pc_reg   <= flush_now ? actual_next : '0;
      err_underflow_reg <= err_underflow_reg || (ex_valid && fifo_empty);
    end
  end

  assign update_pc     = update_pc_reg;
  assign update_BTB    = update_btb_reg;
  assign update_taken  = update_taken_reg;
  assign flush         = flush_reg;
  assign redirect_pc   = redirect_pc_reg;
  assign err_underflow = err_underflow_reg;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_ctrl_reg;
  logic [31:0] stat_mispredict_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ctrl_reg       <= '0;
      stat_mispredict_reg <= '0;
    end else begin
      if (ctrl_pop)  stat_ctrl_reg       <= stat_ctrl_reg + 32'd1;
      if (flush_now) stat_mispredict_reg <= stat_mispredict_reg + 32'd1;
    end
  end

  assign stat_ctrl       = stat_ctrl_reg;
  assign stat_mispredict = stat_mispredict_reg;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic
// against a queue-based reference model of the resolve rules.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [XLEN-1:0] ALL1 = '1;

  logic            clk = 1'b0;
  logic            reset;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pred_next_pc;
  logic            fetch_pred_taken;
  logic            fetch_ready;
  logic            ex_valid;
  logic            ex_is_ctrl;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] update_pc;
  logic [XLEN-1:0] update_BTB;
  logic            update_taken;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            err_underflow;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0]     stat_ctrl;
  logic [31:0]     stat_mispredict;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pn;
  } rec_t;

  rec_t            m_q[$];
  logic [XLEN-1:0] e_upc, e_btb, e_redir;
  logic            e_taken, e_flush, e_err;
  logic [31:0]     e_sctrl, e_smis;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_valid        (fetch_valid),
    .fetch_pc           (fetch_pc),
    .fetch_pred_next_pc (fetch_pred_next_pc),
    .fetch_pred_taken   (fetch_pred_taken),
    .fetch_ready        (fetch_ready),
    .ex_valid           (ex_valid),
    .ex_is_ctrl         (ex_is_ctrl),
    .ex_taken           (ex_taken),
    .ex_target          (ex_target),
    .update_pc          (update_pc),
    .update_BTB         (update_BTB),
    .update_taken       (update_taken),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .err_underflow      (err_underflow)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_ctrl          (stat_ctrl),
    .stat_mispredict    (stat_mispredict)
`endif
  );

  // Reference model: one call per clock edge, from the inputs about to be sampled.
  task automatic model_step();
    int              occ;
    bit              popped;
    bit              mis;
    rec_t            h;
    logic [XLEN-1:0] actual;
    if (reset) begin
      m_q.delete();
      e_upc = ALL1; e_btb = '0; e_taken = 0; e_flush = 0; e_redir = '0; e_err = 0;
      e_sctrl = 0; e_smis = 0;
      return;
    end
    occ    = m_q.size();
    popped = ex_valid && (occ > 0);
    mis    = 0;
    e_upc = ALL1; e_btb = '0; e_taken = 0; e_flush = 0; e_redir = '0;
    if (ex_valid && occ == 0) e_err = 1;
    if (popped) begin
      h = m_q.pop_front();
      actual = ex_taken ? ex_target : h.pc + 32'd4;
      mis = (actual != h.pn);
      if (ex_is_ctrl) begin
        e_upc = h.pc; e_btb = ex_target; e_taken = ex_taken; e_sctrl++;
      end
      if (mis) begin
        e_flush = 1; e_redir = actual; e_smis++;
        m_q.delete();
      end
    end
    if (fetch_valid && !mis && (occ < DEPTH || popped))
      m_q.push_back('{pc: fetch_pc, pn: fetch_pred_next_pc});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_pc = '0; fetch_pred_next_pc = '0; fetch_pred_taken = 0;
    ex_valid = 0; ex_is_ctrl = 0; ex_taken = 0; ex_target = '0;
  endtask

  task automatic set_fetch(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pn);
    fetch_valid = 1; fetch_pc = pc; fetch_pred_next_pc = pn;
    fetch_pred_taken = (pn != pc + 32'd4);
  endtask

  task automatic set_ex(input logic ctrl, input logic tk, input logic [XLEN-1:0] tgt);
    ex_valid = 1; ex_is_ctrl = ctrl; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pn);
    set_fetch(pc, pn); tick(); idle();
  endtask

  task automatic pop(input logic ctrl, input logic tk, input logic [XLEN-1:0] tgt);
    set_ex(ctrl, tk, tgt); tick(); idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; set_fetch(32'h40, 32'h80); set_ex(1, 1, 32'h44);
    tick(); tick(); reset = 0; idle();
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL reset_update_pc got %h want %h", update_pc, ALL1); end
    checks++; if (update_BTB !== 32'h0) begin errors++; $display("FAIL reset_update_btb got %h want 0", update_BTB); end
    checks++; if (update_taken !== 1'b0) begin errors++; $display("FAIL reset_update_taken got %b want 0", update_taken); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready got %b want 1", fetch_ready); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_underflow); end
    $display("test_reset done");
  endtask

  task automatic test_ctrl_not_taken();
    do_reset();
    push(32'h100, 32'h104);
    pop(1, 0, 32'h0);
    checks++; if (update_pc !== 32'h100) begin errors++; $display("FAIL nt_update_pc got %h want 100", update_pc); end
    checks++; if (update_taken !== 1'b0) begin errors++; $display("FAIL nt_update_taken got %b want 0", update_taken); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush got %b want 0", flush); end
    tick();
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL nt_update_pc_pulse got %h want %h", update_pc, ALL1); end
    $display("test_ctrl_not_taken done");
  endtask

  task automatic test_taken_mispredict();
    do_reset();
    push(32'h200, 32'h204);
    pop(1, 1, 32'h300);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tk_flush got %b want 1", flush); end
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL tk_redirect got %h want 300", redirect_pc); end
    checks++; if (update_BTB !== 32'h300) begin errors++; $display("FAIL tk_update_btb got %h want 300", update_BTB); end
    checks++; if (update_pc !== 32'h200) begin errors++; $display("FAIL tk_update_pc got %h want 200", update_pc); end
    checks++; if (update_taken !== 1'b1) begin errors++; $display("FAIL tk_update_taken got %b want 1", update_taken); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL tk_flush_pulse got %b want 0", flush); end
    pop(1, 0, 32'h0);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL tk_queue_empty_err got %b want 1", err_underflow); end
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL tk_underflow_no_update got %h want %h", update_pc, ALL1); end
    $display("test_taken_mispredict done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(16 * i), 32'h1004 + 32'(16 * i));
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fetch_ready); end
    push(32'h2000, 32'h2004);
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after_drop got %b want 0", fetch_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      pop(1, 0, 32'h0);
      checks++; if (update_pc !== 32'h1000 + 32'(16 * i)) begin errors++; $display("FAIL full_order_%0d got %h want %h", i, update_pc, 32'h1000 + 32'(16 * i)); end
    end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL full_err_early got %b want 0", err_underflow); end
    pop(1, 0, 32'h0);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL full_fifth_dropped got %b want 1", err_underflow); end
    $display("test_full done");
  endtask

  task automatic test_full_push_pop();
    logic [XLEN-1:0] exp_pc [4];
    exp_pc[0] = 32'h3010; exp_pc[1] = 32'h3020; exp_pc[2] = 32'h3030; exp_pc[3] = 32'h3100;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h3000 + 32'(16 * i), 32'h3004 + 32'(16 * i));
    set_fetch(32'h3100, 32'h3104); set_ex(1, 0, 32'h0); tick(); idle();
    checks++; if (update_pc !== 32'h3000) begin errors++; $display("FAIL pp_update_pc got %h want 3000", update_pc); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL pp_still_full got %b want 0", fetch_ready); end
    for (int i = 0; i < 4; i++) begin
      pop(1, 0, 32'h0);
      checks++; if (update_pc !== exp_pc[i]) begin errors++; $display("FAIL pp_order_%0d got %h want %h", i, update_pc, exp_pc[i]); end
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_flush_drops_push();
    do_reset();
    push(32'h380, 32'h384);
    set_fetch(32'h400, 32'h404); set_ex(1, 1, 32'h390); tick(); idle();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fd_flush got %b want 1", flush); end
    checks++; if (redirect_pc !== 32'h390) begin errors++; $display("FAIL fd_redirect got %h want 390", redirect_pc); end
    tick();
    pop(1, 0, 32'h0);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL fd_push_dropped got %b want 1", err_underflow); end
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL fd_no_update got %h want %h", update_pc, ALL1); end
    $display("test_flush_drops_push done");
  endtask

  task automatic test_non_ctrl();
    do_reset();
    push(32'h500, 32'h504);
    pop(0, 0, 32'h0);
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL nc_update_pc got %h want %h", update_pc, ALL1); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nc_flush got %b want 0", flush); end
    push(32'h500, 32'h600);
    pop(0, 0, 32'h0);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL nc_mis_flush got %b want 1", flush); end
    checks++; if (redirect_pc !== 32'h504) begin errors++; $display("FAIL nc_mis_redirect got %h want 504", redirect_pc); end
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL nc_mis_update got %h want %h", update_pc, ALL1); end
    $display("test_non_ctrl done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h700 + 32'(16 * i), 32'h704 + 32'(16 * i));
    set_ex(1, 1, 32'h999); set_fetch(32'h800, 32'h804); reset = 1; tick(); reset = 0; idle();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rm_flush got %b want 0", flush); end
    checks++; if (update_pc !== ALL1) begin errors++; $display("FAIL rm_update_pc got %h want %h", update_pc, ALL1); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", fetch_ready); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rm_redirect got %h want 0", redirect_pc); end
    pop(1, 0, 32'h0);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL rm_queue_empty got %b want 1", err_underflow); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [XLEN-1:0] pc;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      fetch_valid = $urandom_range(0, 2) != 0;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      fetch_pc = pc;
      fetch_pred_next_pc = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 63) , 2'b00} : pc + 32'd4;
      fetch_pred_taken = $urandom_range(0, 1);
      ex_valid = $urandom_range(0, 2) == 0;
      ex_is_ctrl = $urandom_range(0, 1);
      ex_taken = $urandom_range(0, 3) == 0;
      ex_target = {$urandom_range(0, 63), 2'b00};
      tick();
      checks++; if (update_pc !== e_upc) begin errors++; $display("FAIL rnd_update_pc cyc %0d got %h want %h", n, update_pc, e_upc); end
      checks++; if (update_BTB !== e_btb) begin errors++; $display("FAIL rnd_update_btb cyc %0d got %h want %h", n, update_BTB, e_btb); end
      checks++; if (update_taken !== e_taken) begin errors++; $display("FAIL rnd_update_taken cyc %0d got %b want %b", n, update_taken, e_taken); end
      checks++; if (flush !== e_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", n, flush, e_flush); end
      checks++; if (redirect_pc !== e_redir) begin errors++; $display("FAIL rnd_redirect cyc %0d got %h want %h", n, redirect_pc, e_redir); end
      checks++; if (fetch_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", n, fetch_ready, m_q.size() < DEPTH); end
      checks++; if (err_underflow !== e_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", n, err_underflow, e_err); end
`ifdef BRANCH_RESOLVER_STATS_EN
      checks++; if (stat_ctrl !== e_sctrl) begin errors++; $display("FAIL rnd_stat_ctrl cyc %0d got %0d want %0d", n, stat_ctrl, e_sctrl); end
      checks++; if (stat_mispredict !== e_smis) begin errors++; $display("FAIL rnd_stat_mis cyc %0d got %0d want %0d", n, stat_mispredict, e_smis); end
`endif
    end
    reset = 0; idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_ctrl_not_taken();
    test_taken_mispredict();
    test_full();
    test_full_push_pop();
    test_flush_drops_push();
    test_non_ctrl();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
